// File: rtl/data_loader_pkg.sv
// Shared definitions for the byte packing writer.
//   state_t        : packer states (EMPTY / HALF / SPILL)
//   BE_*           : byte-enable codes carried with each queued word
//   entry_width()  : queued entry width for a given word-address width.
//                    The entry layout is {word_addr, data[15:0], be[1:0]}.
package data_loader_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,  // nothing held
    ST_HALF  = 2'd1,  // even byte pending, waiting for its odd partner
    ST_SPILL = 2'd2   // odd byte waiting for a free push slot
  } state_t;

  localparam logic [1:0] BE_LO   = 2'b01;
  localparam logic [1:0] BE_HI   = 2'b10;
  localparam logic [1:0] BE_BOTH = 2'b11;

  localparam int ENTRY_META_W = 18;  // 16 data bits + 2 byte enables

  function automatic int entry_width(input int addr_size);
    return addr_size + ENTRY_META_W;
  endfunction

endpackage

// File: rtl/word_fifo.sv
// Synchronous single-clock FIFO with count-based full/empty.
//   gclk, grst_n : clock, async active-low reset (pointers/count only)
//   push, wdata  : write request; accepted when not full or when popping
//   pop          : read request; ignored when empty
//   rdata        : head entry (valid while !empty)
//   full, empty  : occupancy flags
module word_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             gclk,
  input  logic             grst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             wr_en, rd_en;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign rd_en = pop && !empty;
  // A push into a full FIFO still succeeds when the head leaves on the same edge.
  assign wr_en = push && (!full || rd_en);
  assign rdata = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge gclk or negedge grst_n) begin
    if (!grst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge gclk) begin
    if (wr_en) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/byte_pack_writer.sv
// Packs a byte-wide write stream into 16-bit word writes with byte enables.
//   clk_74a, reset_n   : clock, async active-low reset
//   in_en/addr/data    : byte write strobe, byte address, byte data
//   mem_req/ack        : head-of-queue valid / accepted
//   mem_addr/data/be   : word address, word data (even byte low), byte enables
//   overflow           : sticky, a word was dropped on a full queue
//   busy               : a byte is held or a word is queued
module byte_pack_writer
  import data_loader_pkg::*;
#(
  parameter int ADDRESS_SIZE  = 14,
  parameter int FIFO_DEPTH    = 4,
  parameter int FLUSH_TIMEOUT = 16
) (
  input  logic                    clk_74a,
  input  logic                    reset_n,
  input  logic                    in_en,
  input  logic [ADDRESS_SIZE:0]   in_addr,
  input  logic [7:0]              in_data,
  output logic                    mem_req,
  input  logic                    mem_ack,
  output logic [ADDRESS_SIZE-1:0] mem_addr,
  output logic [15:0]             mem_data,
  output logic [1:0]              mem_be,
  output logic                    overflow,
  output logic                    busy
);

  localparam int         EW       = entry_width(ADDRESS_SIZE);
  localparam logic [7:0] TMO_LAST = 8'(FLUSH_TIMEOUT - 1);

  state_t                  state, state_nxt;
  logic [ADDRESS_SIZE-1:0] pend_addr, spill_addr, in_waddr;
  logic [7:0]              pend_data, spill_data;
  logic [7:0]              tmo_cnt, tmo_nxt;
  logic                    in_odd, ld_pend, ld_spill;
  logic                    push, pop, full, empty;
  logic [EW-1:0]           push_entry, head;

  assign in_waddr = in_addr[ADDRESS_SIZE:1];
  assign in_odd   = in_addr[0];
  assign pop      = !empty && mem_ack;

  always_comb begin
    state_nxt  = state;
    tmo_nxt    = '0;
    ld_pend    = 1'b0;
    ld_spill   = 1'b0;
    push       = 1'b0;
    push_entry = '0;
    case (state)
      ST_EMPTY: begin
        if (in_en) begin
          if (in_odd) begin
            push       = 1'b1;
            push_entry = {in_waddr, in_data, 8'h00, BE_HI};
          end else begin
            ld_pend   = 1'b1;
            state_nxt = ST_HALF;
          end
        end
      end
      ST_HALF: begin
        if (in_en) begin
          push = 1'b1;
          if (in_odd && in_waddr == pend_addr) begin
            push_entry = {pend_addr, in_data, pend_data, BE_BOTH};
            state_nxt  = ST_EMPTY;
          end else begin
            // Flush the lone even byte; the new byte replaces it or spills.
            push_entry = {pend_addr, 8'h00, pend_data, BE_LO};
            if (in_odd) begin
              ld_spill  = 1'b1;
              state_nxt = ST_SPILL;
            end else begin
              ld_pend   = 1'b1;
            end
          end
        end else if (tmo_cnt == TMO_LAST) begin
          push       = 1'b1;
          push_entry = {pend_addr, 8'h00, pend_data, BE_LO};
          state_nxt  = ST_EMPTY;
        end else begin
          tmo_nxt = tmo_cnt + 1'b1;
        end
      end
      ST_SPILL: begin
        // Wait for room rather than drop the held odd byte. in_en arriving
        // while stalled here is ignored.
        if (!full || pop) begin
          push       = 1'b1;
          push_entry = {spill_addr, spill_data, 8'h00, BE_HI};
          state_nxt  = ST_EMPTY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
  end

  always_ff @(posedge clk_74a or negedge reset_n) begin
    if (!reset_n) begin
      state      <= ST_EMPTY;
      tmo_cnt    <= '0;
      pend_addr  <= '0;
      pend_data  <= '0;
      spill_addr <= '0;
      spill_data <= '0;
      overflow   <= 1'b0;
    end else begin
      state   <= state_nxt;
      tmo_cnt <= tmo_nxt;
      if (ld_pend) begin
        pend_addr <= in_waddr;
        pend_data <= in_data;
      end
      if (ld_spill) begin
        spill_addr <= in_waddr;
        spill_data <= in_data;
      end
      if (push && full && !pop) overflow <= 1'b1;
    end
  end

  word_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .gclk   (clk_74a),
    .grst_n (reset_n),
    .push   (push),
    .wdata  (push_entry),
    .pop    (pop),
    .rdata  (head),
    .full   (full),
    .empty  (empty)
  );

  // Head storage is not reset, so outputs are forced to zero while empty.
  assign mem_req = !empty;
  assign {mem_addr, mem_data, mem_be} = empty ? '0 : head;
  assign busy = (state != ST_EMPTY) || !empty;

endmodule

// File: doc/byte_pack_writer.md
BYTE_PACK_WRITER -- requirements
Module: byte_pack_writer

Interface
REQ-001 SHALL have parameter ADDRESS_SIZE, default 14, meaning byte address is ADDRESS_SIZE+1 bits wide.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, meaning word FIFO entries (power of two, 2..16).
REQ-003 SHALL have parameter FLUSH_TIMEOUT, default 16, meaning idle cycles before a half word is flushed (1..255).
REQ-004 SHALL have port clk_74a  in  1  the single clock.
REQ-005 SHALL have port reset_n  in  1  reset, asynchronous and active-low.
REQ-006 SHALL have port in_en  in  1  byte write strobe from the loader.
REQ-007 SHALL have port in_addr  in  ADDRESS_SIZE+1  byte address.
REQ-008 SHALL have port in_data  in  8  byte data.
REQ-009 SHALL have port mem_req  out  1  FIFO head valid.
REQ-010 SHALL have port mem_ack  in  1  memory accepted head.
REQ-011 SHALL have port mem_addr  out  ADDRESS_SIZE  word address (in_addr[ADDRESS_SIZE:1]).
REQ-012 SHALL have port mem_data  out  16  word data, even byte in [7:0], odd byte in [15:8].
REQ-013 SHALL have port mem_be  out  2  byte enables, bit0 = low byte, bit1 = high byte.
REQ-014 SHALL have port overflow  out  1  sticky flag set when a word was dropped.
REQ-015 SHALL have port busy  out  1  high while any byte is held or queued.

Function
REQ-016 SHALL require in_en pulses at least 2 cycles apart; behaviour for back-to-back in_en is undefined.
REQ-017 SHALL implement states EMPTY, HALF (even byte pending), SPILL (odd byte waiting for a push slot).
REQ-018 SHALL, in EMPTY, on an even byte: latch it and go to HALF.
REQ-019 SHALL, in EMPTY, on an odd byte: push {addr, data<<8, be=10}, stay EMPTY.
REQ-020 SHALL, in HALF, on an odd byte whose word address equals the pending address: push the combined word with be=11, go to EMPTY.
REQ-021 SHALL, in HALF, on an even byte: push the pending byte with be=01, latch the new byte, stay HALF.
REQ-022 SHALL, in HALF, on a non-matching odd byte: push the pending byte with be=01, hold the odd byte, go to SPILL.
REQ-023 SHALL, in SPILL, push the held byte with be=10 on the next cycle and go to EMPTY.
REQ-024 SHALL, in HALF, count idle cycles and push the pending byte with be=01 when the count reaches FLUSH_TIMEOUT, then go to EMPTY; every accepted byte clears the count.
REQ-025 SHALL perform each push on the clock edge that samples the completing byte or timeout; mem_req SHALL be high in the cycle following that edge when the FIFO was empty.
REQ-026 SHALL drive mem_req = FIFO not empty, with mem_addr/mem_data/mem_be from the head entry; these SHALL stay stable while mem_req && !mem_ack.
REQ-027 SHALL pop on an edge where mem_req && mem_ack; the next entry SHALL be presented in the following cycle without deasserting mem_req.
REQ-028 SHALL, on push while full without a same-cycle pop, drop the word and set overflow; a simultaneous push and pop when full SHALL succeed.
REQ-029 SHALL hold the SPILL push (stay in SPILL) while the FIFO is full with no pop, rather than drop it.
REQ-030 SHALL clear overflow only on reset.
REQ-031 SHALL drive busy = (state != EMPTY) || FIFO not empty.

Reset
REQ-032 SHALL, on reset_n low, asynchronously clear the FIFO, state = EMPTY, timeout count = 0, mem_req = 0, mem_addr = 0, mem_data = 0, mem_be = 0, overflow = 0, busy = 0.
REQ-033 SHALL discard pending or queued bytes on reset mid-operation, with no partial write issued afterward.

Structure
REQ-034 SHALL keep state encodings, be codes (01/10/11) and the entry width (ADDRESS_SIZE+18) in the shared package data_loader_pkg.
REQ-035 SHALL implement the queue as a sub-module word_fifo (synchronous, single clock, count-based full/empty).

Verification
REQ-036 SHALL cover: bytes 0x11@0x0004, 0x22@0x0005 -> one write addr 0x0002, data 0x2211, be 11.
REQ-037 SHALL cover: 0xAA@0x0006, then idle 16 cycles -> write addr 0x0003, data 0x00AA, be 01 at timeout.
REQ-038 SHALL cover: 0x33@0x0008 then 0x44@0x000B -> addr 0x0004 be 01 data 0x0033, then addr 0x0005 be 10 data 0x4400.
REQ-039 SHALL cover: mem_ack held low, 5 full words (10 bytes) -> 4 queued, overflow = 1, busy = 1; then mem_ack high -> 4 writes in order, busy = 0.
REQ-040 SHALL cover: reset_n pulsed low while HALF with 2 words queued -> mem_req = 0 immediately, no further writes.
